// File: rtl/alu_seq_param.sv
// alu_seq_param: clocked WIDTH-bit ALU with operand/result registers
// and an iterative shift-add multiplier taking WIDTH cycles.
module alu_seq_param #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    input  logic [4:0]       op_sel,
    input  logic [WIDTH-1:0] din,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] a_q,
    output logic [WIDTH-1:0] b_q,
    output logic [WIDTH-1:0] y_q,
    output logic [WIDTH-1:0] h_q,
    output logic             flag_c,
    output logic             flag_z
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, MUL} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic               accept;
    logic               mul_last;
    logic [WIDTH-1:0]   alu_y;
    logic               alu_c;
    logic               wr_y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = (state == IDLE) && op_valid;
        mul_last  = (state == MUL) && (cnt == CW'(1));
        unique case (state)
            IDLE: if (accept && op_sel == 5'h10) state_nxt = MUL;
            MUL:  if (mul_last) state_nxt = IDLE;
        endcase
    end

    assign acc_nxt = acc + (mplier[0] ? mcand : '0);

    // Y-writing opcodes; register-move opcodes clear wr_y
    always_comb begin
        alu_y = '0;
        alu_c = 1'b0;
        wr_y  = 1'b1;
        unique case (op_sel)
            5'h00: {alu_c, alu_y} = {1'b0, a_q} + {1'b0, b_q};
            5'h01: {alu_c, alu_y} = {1'b0, a_q} - {1'b0, b_q};
            5'h02: {alu_c, alu_y} = {a_q, 1'b0};
            5'h03: {alu_y, alu_c} = {1'b0, a_q};
            5'h04: begin
                if (a_q == b_q)     alu_y = '0;
                else if (a_q > b_q) alu_y = WIDTH'(1);
                else                alu_y = '1;
            end
            5'h05: alu_y = a_q & b_q;
            5'h06: alu_y = a_q | b_q;
            5'h07: alu_y = a_q ^ b_q;
            5'h08: alu_y = ~(a_q & b_q);
            5'h09: alu_y = ~(a_q | b_q);
            5'h0A: alu_y = ~(a_q ^ b_q);
            5'h0B: alu_y = ~a_q;
            5'h0C: begin
                alu_y = -a_q;
                alu_c = |a_q;
            end
            5'h0D, 5'h0E, 5'h0F,
            5'h10, 5'h11, 5'h12: wr_y = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            y_q    <= '0;
            h_q    <= '0;
            flag_c <= 1'b0;
            flag_z <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                done <= (op_sel != 5'h10);
                if (wr_y) begin
                    y_q    <= alu_y;
                    flag_c <= alu_c;
                    flag_z <= (alu_y == '0);
                end
                unique case (op_sel)
                    5'h0D: a_q <= y_q;
                    5'h0E: begin
                        a_q <= b_q;
                        b_q <= a_q;
                    end
                    5'h0F: a_q <= din;
                    5'h11: b_q <= din;
                    5'h12: begin
                        a_q    <= '0;
                        b_q    <= '0;
                        y_q    <= '0;
                        h_q    <= '0;
                        flag_c <= 1'b0;
                        flag_z <= 1'b0;
                    end
                    5'h10: begin
                        mcand  <= {{WIDTH{1'b0}}, a_q};
                        mplier <= b_q;
                        acc    <= '0;
                        cnt    <= CW'(WIDTH);
                        busy   <= 1'b1;
                    end
                    default: ;
                endcase
            end else if (state == MUL) begin
                acc    <= acc_nxt;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt - CW'(1);
                if (mul_last) begin
                    h_q    <= acc_nxt[2*WIDTH-1:WIDTH];
                    y_q    <= acc_nxt[WIDTH-1:0];
                    flag_z <= (acc_nxt == '0);
                    flag_c <= |acc_nxt[2*WIDTH-1:WIDTH];
                    busy   <= 1'b0;
                    done   <= 1'b1;
                end
            end
        end
    end

endmodule
